pcie_dplbuf_arb: RTL
====================

# pcie_dplbuf_arb

Round-robin arbiter sharing the DPL buffer between `PORTS` link requesters in the PCIe application layer. It grants one link at a time and holds that grant until the link's block transfer completes. A watchdog revokes grants that stall.
- Drives the `DPLBUF_GNT` vector and the `LINK_NUM`/`BLK_DONE` sideband that the performance-counter path consumes.

## Interface
Parameters:
- `PORTS`, 12, number of requesting links
- `PORT_WIDTH`, `$clog2(PORTS)`, link index width
- `TIMEOUT_CYC`, 65536, maximum cycles a grant may be held without `iBLK_DONE`; legal range 2..2^32-1

Ports:
- `clk`  in  1  single clock domain
- `rst_n`  in  1  reset; asynchronous, active-low
- `iDPLBUF_REQ`  in  PORTS  per-link request, level; held until own block done
- `iPORT_EN`  in  PORTS  eligibility mask; 0 = port never newly granted
- `iBLK_DONE`  in  1  one-cycle pulse; the currently granted link finished its block
- `oDPLBUF_GNT`  out  PORTS  one-hot-or-zero grant, registered
- `oLINK_NUM`  out  PORT_WIDTH  index of the granted link; holds its last value when no grant is active
- `oGNT_VAL`  out  1  a grant is active (equals `|oDPLBUF_GNT`)
- `oBLK_DONE`  out  1  registered copy of `iBLK_DONE` when it is accepted in GRANT
- `oTIMEOUT`  out  1  one-cycle pulse when the watchdog revokes a grant
- `oTIMEOUT_LINK`  out  PORT_WIDTH  link revoked by the last timeout; holds until the next timeout

## Operation
- States: IDLE, GRANT.
- IDLE:
  - Eligible set is `iDPLBUF_REQ & iPORT_EN`.
  - If the set is non-zero, pick the first set bit at or after `rr_ptr`, searching upward and wrapping from PORTS-1 to 0.
  - Register the pick into `oDPLBUF_GNT`/`oLINK_NUM`, clear the watchdog, go to GRANT.
- GRANT exits, in priority order:
  1. `iBLK_DONE`=1: release the grant, `oBLK_DONE`=1 for one cycle, go to IDLE.
  2. `iDPLBUF_REQ[oLINK_NUM]`=0: abort; release the grant, no `oBLK_DONE`, no `oTIMEOUT`, go to IDLE.
  3. Watchdog equals `TIMEOUT_CYC-1`: release the grant, pulse `oTIMEOUT`, load `oTIMEOUT_LINK`=`oLINK_NUM`, go to IDLE.
  4. Otherwise increment the watchdog and stay in GRANT.
- On every GRANT exit, `rr_ptr` <= `oLINK_NUM+1`, wrapping PORTS-1 -> 0.
- `rr_ptr` width is PORT_WIDTH. Values >= PORTS are never produced.
- The watchdog is a 32-bit saturating counter and is reset on entry to GRANT.
- Clearing `iPORT_EN` for the granted port does not revoke the grant. It only blocks future grants.
- `iBLK_DONE` in IDLE is ignored: no `oBLK_DONE`, no state change.
- Reset (asynchronous assert, any state) forces:
  - state IDLE, `rr_ptr`=0, watchdog=0
  - `oDPLBUF_GNT`=0, `oLINK_NUM`=0, `oGNT_VAL`=0
  - `oBLK_DONE`=0, `oTIMEOUT`=0, `oTIMEOUT_LINK`=0
- Deassertion of reset is synchronized externally. The first arbitration happens on the first clock edge after release.

## Timing
- Request to grant latency from IDLE: request sampled at edge N, `oDPLBUF_GNT` high after edge N+1 (1 cycle).
- Done to release: `iBLK_DONE` sampled at edge N clears `oDPLBUF_GNT` and sets `oBLK_DONE` after edge N+1.
- The next grant can appear at the earliest after edge N+2. There is a minimum of one idle cycle between grants.
- Timeout: the grant is visible for exactly `TIMEOUT_CYC` cycles, then drops in the same cycle `oTIMEOUT` pulses.
- `iBLK_DONE` coinciding with the terminal watchdog count is treated as done: no timeout.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Fairness: a continuously requesting, enabled port waits at most PORTS-1 grants.

## Structure
- `pcie_app_pkg` holds:
  - `typedef enum logic {ARB_IDLE, ARB_GRANT} dplbuf_arb_st_t`
  - `localparam DPLBUF_TIMEOUT_DEF = 65536`
- Sub-module `pcie_rr_pick`: combinational round-robin picker.
  - Inputs: `req[PORTS]`, `ptr[PORT_WIDTH]`.
  - Outputs: `gnt_onehot`, `gnt_idx`, `any`.
  - Implemented with the double-width masked priority-encode method.
- Top level contains the state register, watchdog, `rr_ptr` and output registers.

## Test plan
- Single request: `iDPLBUF_REQ`=12'h004, `iPORT_EN`=all ones -> `oDPLBUF_GNT`=12'h004 and `oLINK_NUM`=2 one cycle later. `iBLK_DONE` pulse -> grant drops next cycle with `oBLK_DONE`=1.
- Rotation: all 12 requests held, done issued 2 cycles after each grant -> grant order 0,1,...,11,0. The gap between consecutive grants is always exactly 1 idle cycle.
- Mask: REQ=12'hFFF, `iPORT_EN`=12'hFF0 -> ports 0-3 are never granted, 4-11 rotate. Clearing EN[5] while 5 is granted keeps the grant until done.
- Timeout: `TIMEOUT_CYC`=16, port 7 granted, no done -> grant high exactly 16 cycles, `oTIMEOUT`=1 for one cycle, `oTIMEOUT_LINK`=7, next grant goes to port 8 if it is requesting.
- Abort and stray done: drop REQ[3] while it is granted -> grant released next cycle, no `oBLK_DONE`/`oTIMEOUT`. `iBLK_DONE` in IDLE -> no output change.
- Reset mid-grant: assert `rst_n`=0 asynchronously between edges while port 9 is granted -> all outputs 0 immediately. After release, REQ=12'hFFF gives the first grant to port 0.

Source files
------------

// File: rtl/pcie_app_pkg.sv
// ---------------------------------------------------------------------------
// pcie_app_pkg
// Shared types and constants for the PCIe application-layer DPL buffer
// arbiter.
//   dplbuf_arb_st_t    : arbiter FSM state (idle / grant held)
//   DPLBUF_TIMEOUT_DEF : default watchdog limit in clock cycles
//   rr_next_idx()      : round-robin successor of a link index, wrapping to 0
// ---------------------------------------------------------------------------
package pcie_app_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } dplbuf_arb_st_t;

    localparam int unsigned DPLBUF_TIMEOUT_DEF = 32'd65536;

    // Successor of cur in a ring of 'ports' entries (ports-1 wraps to 0).
    function automatic int unsigned rr_next_idx(input int unsigned cur,
                                                input int unsigned ports);
        int unsigned nxt;
        if ((cur + 32'd1) >= ports) begin
            nxt = 32'd0;
        end else begin
            nxt = cur + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pcie_rr_pick.sv
// ---------------------------------------------------------------------------
// pcie_rr_pick
// Combinational round-robin picker. It returns the first set bit of req
// at or above ptr, searching upward and wrapping from PORTS-1 to 0.
//   req        in  PORTS       candidate vector
//   ptr        in  PORT_WIDTH  search start index (always < PORTS)
//   gnt_onehot out PORTS       one-hot pick (zero when req is zero)
//   gnt_idx    out PORT_WIDTH  binary index of the pick
//   any        out 1           req is non-zero
// ---------------------------------------------------------------------------
module pcie_rr_pick #(
    parameter int PORTS      = 12,
    parameter int PORT_WIDTH = $clog2(PORTS)
) (
    input  logic [PORTS-1:0]      req,
    input  logic [PORT_WIDTH-1:0] ptr,
    output logic [PORTS-1:0]      gnt_onehot,
    output logic [PORT_WIDTH-1:0] gnt_idx,
    output logic                  any
);

    localparam int DW = 2 * PORTS;

    logic [DW-1:0] w_dbl;
    logic [DW-1:0] w_mask;
    logic [DW-1:0] w_masked;
    logic [DW-1:0] w_iso;

    // The request vector is laid out twice and the bits below ptr are masked
    // off. The upper copy is never masked because ptr < PORTS, so the wrapped
    // candidates always remain available. The lowest surviving bit is the
    // round-robin winner, and it is isolated with x & -x.
    assign w_dbl      = {req, req};
    assign w_mask     = {DW{1'b1}} << ptr;
    assign w_masked   = w_dbl & w_mask;
    assign w_iso      = w_masked & (~w_masked + {{(DW-1){1'b0}}, 1'b1});
    assign gnt_onehot = w_iso[PORTS-1:0] | w_iso[DW-1:PORTS];
    assign any        = |req;

    // One-hot to binary encode of the winner.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (gnt_onehot[i]) begin
                gnt_idx = gnt_idx | PORT_WIDTH'(i);
            end else begin
                gnt_idx = gnt_idx;
            end
        end
    end

endmodule

// File: rtl/pcie_dplbuf_arb.sv
// ---------------------------------------------------------------------------
// pcie_dplbuf_arb
// Round-robin arbiter for the shared DPL buffer. It grants one link at a time
// and holds the grant until the link's block completes, the link drops its
// request, or the watchdog expires.
//   clk           in  1           clock
//   rst_n         in  1           asynchronous active-low reset
//   iDPLBUF_REQ   in  PORTS       per-link request level
//   iPORT_EN      in  PORTS       eligibility mask for new grants
//   iBLK_DONE     in  1           granted link finished its block (pulse)
//   oDPLBUF_GNT   out PORTS       one-hot-or-zero grant
//   oLINK_NUM     out PORT_WIDTH  granted link; holds its value while idle
//   oGNT_VAL      out 1           a grant is active
//   oBLK_DONE     out 1           accepted block-done pulse
//   oTIMEOUT      out 1           watchdog revoked the grant (pulse)
//   oTIMEOUT_LINK out PORT_WIDTH  link revoked by the last timeout
// All outputs are driven directly from flops.
// ---------------------------------------------------------------------------
module pcie_dplbuf_arb
    import pcie_app_pkg::*;
#(
    parameter int          PORTS       = 12,
    parameter int          PORT_WIDTH  = $clog2(PORTS),
    parameter int unsigned TIMEOUT_CYC = DPLBUF_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PORTS-1:0]      iDPLBUF_REQ,
    input  logic [PORTS-1:0]      iPORT_EN,
    input  logic                  iBLK_DONE,
    output logic [PORTS-1:0]      oDPLBUF_GNT,
    output logic [PORT_WIDTH-1:0] oLINK_NUM,
    output logic                  oGNT_VAL,
    output logic                  oBLK_DONE,
    output logic                  oTIMEOUT,
    output logic [PORT_WIDTH-1:0] oTIMEOUT_LINK
);

    // The watchdog counts from 0 on the first grant cycle. Reaching
    // TIMEOUT_CYC-1 at a clock edge therefore means the grant has been
    // visible for TIMEOUT_CYC cycles.
    localparam logic [31:0] WD_TERM = 32'(TIMEOUT_CYC - 32'd1);
    localparam logic [31:0] WD_MAX  = 32'hFFFF_FFFF;

    dplbuf_arb_st_t        r_state;
    dplbuf_arb_st_t        w_state_nxt;
    logic [PORT_WIDTH-1:0] r_rr_ptr;
    logic [PORT_WIDTH-1:0] w_rr_ptr_nxt;
    logic [31:0]           r_wd;
    logic [31:0]           w_wd_nxt;
    logic [PORTS-1:0]      r_gnt;
    logic [PORTS-1:0]      w_gnt_nxt;
    logic [PORT_WIDTH-1:0] r_link_num;
    logic [PORT_WIDTH-1:0] w_link_nxt;
    logic                  r_gnt_val;
    logic                  r_blk_done;
    logic                  w_blk_done_nxt;
    logic                  r_timeout;
    logic                  w_timeout_nxt;
    logic [PORT_WIDTH-1:0] r_timeout_link;
    logic [PORT_WIDTH-1:0] w_timeout_link_nxt;

    logic [PORTS-1:0]      w_elig;
    logic [PORTS-1:0]      w_pick_onehot;
    logic [PORT_WIDTH-1:0] w_pick_idx;
    logic                  w_pick_any;
    logic [PORT_WIDTH-1:0] w_ptr_after;

    assign w_elig      = iDPLBUF_REQ & iPORT_EN;
    assign w_ptr_after = PORT_WIDTH'(rr_next_idx(32'(r_link_num), 32'(PORTS)));

    pcie_rr_pick #(
        .PORTS      (PORTS),
        .PORT_WIDTH (PORT_WIDTH)
    ) u_pick (
        .req        (w_elig),
        .ptr        (r_rr_ptr),
        .gnt_onehot (w_pick_onehot),
        .gnt_idx    (w_pick_idx),
        .any        (w_pick_any)
    );

    // Next-state and next-output decode. The GRANT exits are checked in
    // priority order: done, abort, then watchdog expiry.
    always_comb begin
        w_state_nxt        = r_state;
        w_rr_ptr_nxt       = r_rr_ptr;
        w_wd_nxt           = r_wd;
        w_gnt_nxt          = r_gnt;
        w_link_nxt         = r_link_num;
        w_blk_done_nxt     = 1'b0;
        w_timeout_nxt      = 1'b0;
        w_timeout_link_nxt = r_timeout_link;

        case (r_state)
            ARB_IDLE: begin
                // A done pulse seen here belongs to no grant and is ignored.
                if (w_pick_any) begin
                    w_state_nxt = ARB_GRANT;
                    w_gnt_nxt   = w_pick_onehot;
                    w_link_nxt  = w_pick_idx;
                    w_wd_nxt    = 32'd0;
                end else begin
                    w_gnt_nxt   = {PORTS{1'b0}};
                end
            end
            ARB_GRANT: begin
                if (iBLK_DONE) begin
                    w_state_nxt    = ARB_IDLE;
                    w_gnt_nxt      = {PORTS{1'b0}};
                    w_rr_ptr_nxt   = w_ptr_after;
                    w_blk_done_nxt = 1'b1;
                end else if (!iDPLBUF_REQ[r_link_num]) begin
                    w_state_nxt  = ARB_IDLE;
                    w_gnt_nxt    = {PORTS{1'b0}};
                    w_rr_ptr_nxt = w_ptr_after;
                end else if (r_wd == WD_TERM) begin
                    w_state_nxt        = ARB_IDLE;
                    w_gnt_nxt          = {PORTS{1'b0}};
                    w_rr_ptr_nxt       = w_ptr_after;
                    w_timeout_nxt      = 1'b1;
                    w_timeout_link_nxt = r_link_num;
                end else if (r_wd != WD_MAX) begin
                    w_wd_nxt = r_wd + 32'd1;
                end else begin
                    w_wd_nxt = r_wd;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_gnt_nxt   = {PORTS{1'b0}};
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Round-robin pointer, watchdog and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr       <= '0;
            r_wd           <= 32'd0;
            r_gnt          <= {PORTS{1'b0}};
            r_link_num     <= '0;
            r_gnt_val      <= 1'b0;
            r_blk_done     <= 1'b0;
            r_timeout      <= 1'b0;
            r_timeout_link <= '0;
        end else begin
            r_rr_ptr       <= w_rr_ptr_nxt;
            r_wd           <= w_wd_nxt;
            r_gnt          <= w_gnt_nxt;
            r_link_num     <= w_link_nxt;
            r_gnt_val      <= |w_gnt_nxt;
            r_blk_done     <= w_blk_done_nxt;
            r_timeout      <= w_timeout_nxt;
            r_timeout_link <= w_timeout_link_nxt;
        end
    end

    assign oDPLBUF_GNT   = r_gnt;
    assign oLINK_NUM     = r_link_num;
    assign oGNT_VAL      = r_gnt_val;
    assign oBLK_DONE     = r_blk_done;
    assign oTIMEOUT      = r_timeout;
    assign oTIMEOUT_LINK = r_timeout_link;

endmodule
